pll_lock_supervisor: RTL and testbench

Controls the PLL's rst/locked handshake from the requesting side. It pulses the PLL reset and waits for a stable lock, then releases the system reset. If lock never arrives it retries a limited number of times. If lock is lost while running, it re-asserts system reset and restarts the PLL. It runs on the 50 MHz board reference clock, ahead of all CPU clock domains.

---
 rtl/pll_sup_pkg.sv | 20 ++
 rtl/pll_lock_supervisor_if.sv | 26 ++
 rtl/pll_lock_supervisor_sync_2ff.sv | 21 ++
 rtl/pll_lock_supervisor.sv | 116 +++++++++++
 tb/tb_pll_lock_supervisor.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/pll_sup_pkg.sv
// Shared types and constants for the PLL lock supervisor.
package pll_sup_pkg;

  typedef enum logic [2:0] {
    PLL_RESET = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3,
    FAIL      = 3'd4
  } pll_sup_state_e;

  localparam int RELOCK_MAX = 255;
  localparam int RETRY_W    = 8;

  // Saturating increment; the relock counter must never wrap to 0.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'(RELOCK_MAX)) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/pll_lock_supervisor_if.sv
// Signal bundle between the supervisor (master) and the PLL/system side (slave).
interface pll_lock_supervisor_if;
  import pll_sup_pkg::*;

  // Level handshake, not valid/ready: the supervisor holds pll_rst high for a
  // pulse, the PLL answers with a level on locked (async to refclk); sys_rst
  // stays high until locked has been seen stable, and lock_fail is sticky until rst.
  logic           locked;
  logic           pll_rst;
  logic           sys_rst;
  logic           lock_fail;
  logic [7:0]     relock_count;
  pll_sup_state_e state_dbg;
  logic [7:0]     retry_dbg;

  modport master (
    input  locked,
    output pll_rst, sys_rst, lock_fail, relock_count, state_dbg, retry_dbg
  );

  modport slave (
    output locked,
    input  pll_rst, sys_rst, lock_fail, relock_count, state_dbg, retry_dbg
  );

endinterface

// File: rtl/pll_lock_supervisor_sync_2ff.sv
// Two-flop synchronizer for one asynchronous level input, synchronous reset to 0.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_lock_supervisor.sv
// Sequences the PLL reset pulse, waits for a stable lock, then releases sys_rst;
// retries on lock timeout and restarts the PLL on lock loss while running.
module pll_lock_supervisor
  import pll_sup_pkg::*;
#(
  parameter int RST_PULSE_CYCLES    = 16,
  parameter int LOCK_TIMEOUT_CYCLES = 65536,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int MAX_RETRIES         = 4,
  parameter int CNT_W               = 17
) (
  input  logic                  refclk,
  input  logic                  rst,
  pll_lock_supervisor_if.master bus
);

  localparam logic [CNT_W-1:0]   RST_LAST    = CNT_W'(RST_PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0]   STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_LIMIT = RETRY_W'(MAX_RETRIES);

  pll_sup_state_e     state, state_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [RETRY_W-1:0] retry_cnt, retry_n;
  logic [7:0]         relock_count, relock_n;
  logic               locked_s;
  logic               pll_rst_q, sys_rst_q, lock_fail_q;

  sync_2ff u_lock_sync (
    .clk (refclk),
    .rst (rst),
    .d   (bus.locked),
    .q   (locked_s)
  );

  always_comb begin
    state_n  = state;
    cnt_n    = cnt + 1'b1;
    retry_n  = retry_cnt;
    relock_n = relock_count;
    case (state)
      PLL_RESET: begin
        if (cnt == RST_LAST) begin
          state_n = WAIT_LOCK;
          cnt_n   = '0;
        end
      end
      WAIT_LOCK: begin
        if (locked_s) begin
          state_n = STABLE;
          cnt_n   = '0;
        end else if (cnt == TIMEOUT_LAST) begin
          retry_n = retry_cnt + 1'b1;
          cnt_n   = '0;
          state_n = (retry_n == RETRY_LIMIT) ? FAIL : PLL_RESET;
        end
      end
      STABLE: begin
        // A dropout restarts the timeout without charging a retry.
        if (!locked_s) begin
          state_n = WAIT_LOCK;
          cnt_n   = '0;
        end else if (cnt == STABLE_LAST) begin
          state_n = RUN;
          cnt_n   = '0;
          retry_n = '0;
        end
      end
      RUN: begin
        cnt_n = cnt;
        if (!locked_s) begin
          state_n  = PLL_RESET;
          cnt_n    = '0;
          relock_n = sat_inc8(relock_count);
        end
      end
      FAIL: begin
        cnt_n = cnt;
      end
      default: begin
        state_n = PLL_RESET;
        cnt_n   = '0;
      end
    endcase
  end

  // Outputs are registered from the next state so they change on the same
  // edge as the state register and never glitch.
  always_ff @(posedge refclk) begin
    if (rst) begin
      state        <= PLL_RESET;
      cnt          <= '0;
      retry_cnt    <= '0;
      relock_count <= '0;
      pll_rst_q    <= 1'b1;
      sys_rst_q    <= 1'b1;
      lock_fail_q  <= 1'b0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      retry_cnt    <= retry_n;
      relock_count <= relock_n;
      pll_rst_q    <= (state_n == PLL_RESET);
      sys_rst_q    <= (state_n != RUN);
      lock_fail_q  <= (state_n == FAIL);
    end
  end

  assign bus.pll_rst      = pll_rst_q;
  assign bus.sys_rst      = sys_rst_q;
  assign bus.lock_fail    = lock_fail_q;
  assign bus.relock_count = relock_count;
  assign bus.state_dbg    = state;
  assign bus.retry_dbg    = retry_cnt;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Bench for pll_lock_supervisor: directed scenarios plus random lock traffic,
// checked every cycle against a countdown-based reference model.
module tb_pll_lock_supervisor;
  import pll_sup_pkg::*;

  localparam int RP = 4;
  localparam int TO = 32;
  localparam int ST = 8;
  localparam int MR = 2;
  localparam int CW = 6;
  localparam int W  = 19;

  localparam int PH_PULSE  = 0;
  localparam int PH_WAIT   = 1;
  localparam int PH_SETTLE = 2;
  localparam int PH_RUN    = 3;
  localparam int PH_DEAD   = 4;

  // clock / reset
  logic refclk = 1'b0;
  logic rst    = 1'b1;
  always #10 refclk = ~refclk;

  pll_lock_supervisor_if bus ();

  pll_lock_supervisor #(
    .RST_PULSE_CYCLES    (RP),
    .LOCK_TIMEOUT_CYCLES (TO),
    .LOCK_STABLE_CYCLES  (ST),
    .MAX_RETRIES         (MR),
    .CNT_W               (CW)
  ) dut (
    .refclk (refclk),
    .rst    (rst),
    .bus    (bus)
  );

  int checks   = 0;
  int failures = 0;
  logic [W-1:0] exp_q[$];

  // reference model: phase plus cycles remaining in that phase
  int   m_ph, m_left, m_tries, m_relocks;
  logic lk_hist[$];

  logic obs_pll, obs_sys, obs_fail;
  logic [7:0] obs_relock, obs_retry;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic model_edge(input logic r, input logic l);
    logic ls;
    if (r) begin
      m_ph = PH_PULSE; m_left = RP; m_tries = 0; m_relocks = 0;
      lk_hist = '{1'b0, 1'b0};
    end else begin
      ls = lk_hist.pop_front();
      lk_hist.push_back(l);
      case (m_ph)
        PH_PULSE: begin
          m_left--;
          if (m_left == 0) begin m_ph = PH_WAIT; m_left = TO; end
        end
        PH_WAIT: begin
          if (ls) begin m_ph = PH_SETTLE; m_left = ST; end
          else begin
            m_left--;
            if (m_left == 0) begin
              m_tries++;
              if (m_tries == MR) m_ph = PH_DEAD;
              else begin m_ph = PH_PULSE; m_left = RP; end
            end
          end
        end
        PH_SETTLE: begin
          if (!ls) begin m_ph = PH_WAIT; m_left = TO; end
          else begin
            m_left--;
            if (m_left == 0) begin m_ph = PH_RUN; m_tries = 0; end
          end
        end
        PH_RUN: begin
          if (!ls) begin
            m_ph = PH_PULSE; m_left = RP;
            if (m_relocks < RELOCK_MAX) m_relocks++;
          end
        end
        default: ;
      endcase
    end
  endtask

  // driver: observe at negedge, drive, predict the next edge, queue it
  task automatic step(input logic r, input logic l);
    logic [W-1:0] e;
    @(negedge refclk);
    obs_pll = bus.pll_rst; obs_sys = bus.sys_rst; obs_fail = bus.lock_fail;
    obs_relock = bus.relock_count; obs_retry = bus.retry_dbg;
    rst = r;
    bus.locked = l;
    model_edge(r, l);
    e = {(m_ph == PH_PULSE), (m_ph != PH_RUN), (m_ph == PH_DEAD),
         8'(m_relocks), 8'(m_tries)};
    exp_q.push_back(e);
  endtask

  // monitor / scoreboard
  initial begin
    logic [W-1:0] e, a;
    forever begin
      @(posedge refclk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = {bus.pll_rst, bus.sys_rst, bus.lock_fail, bus.relock_count, bus.retry_dbg};
        checks++;
        if (a !== e) begin
          failures++;
          $display("FAIL scoreboard t=%0t actual={pll %b sys %b fail %b relock %0d retry %0d} expected={pll %b sys %b fail %b relock %0d retry %0d}",
                   $time, a[18], a[17], a[16], a[15:8], a[7:0], e[18], e[17], e[16], e[15:8], e[7:0]);
        end
      end
    end
  end

  initial begin
    int   n, falls, run_left;
    logic prev, lk;
    bus.locked = 1'b0;
    model_edge(1'b1, 1'b0);

    // 1: power-up, lock arrives, release latency
    step(1, 0); step(1, 0);
    repeat (RP + 5) step(0, 0);
    step(0, 1);
    n = 0;
    do begin step(0, 1); n++; end while (obs_sys !== 1'b0 && n < 60);
    check("release_latency", n - 1, ST + 2);
    check("lock_fail_after_lock", int'(obs_fail), 0);
    repeat (5) step(0, 1);

    // 2: never locks -> MR pulses then FAIL
    step(1, 0);
    falls = 0; prev = 1'b1;
    for (int i = 0; i < 200; i++) begin
      step(0, 0);
      if (prev && !obs_pll) falls++;
      prev = obs_pll;
    end
    check("pll_pulses_before_fail", falls, MR);
    check("lock_fail_in_fail", int'(obs_fail), 1);
    check("sys_rst_in_fail", int'(obs_sys), 1);
    check("pll_rst_in_fail", int'(obs_pll), 0);

    // 3: dropout during settling at count 5
    step(1, 0);
    for (int i = 0; i < 100 && !(m_ph == PH_SETTLE && m_left == ST - 5); i++) step(0, 1);
    step(0, 0); step(0, 0);
    step(0, 1);
    n = 0;
    do begin step(0, 1); n++; end while (obs_sys !== 1'b0 && n < 60);
    check("release_after_dropout", n - 1, ST + 2);
    check("retry_after_dropout", int'(obs_retry), 0);

    // 4: lock loss in RUN and relock
    repeat (3) step(0, 0);
    for (int i = 0; i < 100 && m_ph != PH_RUN; i++) step(0, 1);
    repeat (3) step(0, 1);
    check("relock_count_one", int'(obs_relock), 1);
    check("retry_after_relock", int'(obs_retry), 0);
    check("sys_rst_back_in_run", int'(obs_sys), 0);

    // 5: rst in WAIT_LOCK and in FAIL
    for (int i = 0; i < 100 && m_ph != PH_WAIT; i++) step(0, 0);
    repeat (3) step(0, 0);
    step(1, 0); step(0, 0);
    check("rst_wait_pll", int'(obs_pll), 1);
    check("rst_wait_sys", int'(obs_sys), 1);
    check("rst_wait_relock", int'(obs_relock), 0);
    for (int i = 0; i < 200 && m_ph != PH_DEAD; i++) step(0, 0);
    repeat (3) step(0, 0);
    step(1, 0); step(0, 0);
    check("rst_fail_lock_fail", int'(obs_fail), 0);
    check("rst_fail_pll", int'(obs_pll), 1);
    check("rst_fail_sys", int'(obs_sys), 1);

    // 6: 260 lock losses -> saturation
    step(1, 0);
    for (int c = 0; c < 260; c++) begin
      for (int i = 0; i < 100 && m_ph != PH_RUN; i++) step(0, 1);
      repeat ($urandom_range(0, 3)) step(0, 1);
      repeat ($urandom_range(1, 3)) step(0, 0);
      for (int i = 0; i < 10 && m_ph == PH_RUN; i++) step(0, 1);
    end
    for (int i = 0; i < 100 && m_ph != PH_RUN; i++) step(0, 1);
    repeat (3) step(0, 1);
    check("relock_saturated", int'(obs_relock), RELOCK_MAX);

    // 7: random lock traffic with occasional rst
    run_left = 0; lk = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      if (run_left == 0) begin
        lk = 1'($urandom_range(0, 1));
        run_left = $urandom_range(1, 40);
      end
      step(($urandom_range(0, 199) == 0), lk);
      run_left--;
    end

    step(0, 0);
    repeat (3) @(posedge refclk);
    #2;
    check("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
